// File: rtl/perf_timer_pkg.sv
// Shared encodings for the multi-channel interval timer: read-field codes,
// channel state and status-word bit positions.
package perf_timer_pkg;

  localparam logic [2:0] FLD_BEGIN    = 3'd0;
  localparam logic [2:0] FLD_END      = 3'd1;
  localparam logic [2:0] FLD_ELAPSED  = 3'd2;
  localparam logic [2:0] FLD_ACCUM_LO = 3'd3;
  localparam logic [2:0] FLD_ACCUM_HI = 3'd4;
  localparam logic [2:0] FLD_COUNT    = 3'd5;
  localparam logic [2:0] FLD_STATUS   = 3'd6;
  localparam logic [2:0] FLD_TS       = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  localparam int ST_RUN_BIT = 0;
  localparam int ST_ERR_BIT = 1;
  localparam int ST_OVF_BIT = 2;

endpackage

// File: rtl/perf_interval_chan.sv
// One interval-measurement channel: start/stop FSM, begin/end/elapsed capture,
// saturating accumulated total and interval count, sticky err/ovf flags.
module perf_interval_chan #(
  parameter int W  = 32,
  parameter int AW = 48,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  ts,
  input  logic          start,
  input  logic          stop,
  input  logic          clr,
  output logic [W-1:0]  begin_ts,
  output logic [W-1:0]  end_ts,
  output logic [W-1:0]  elapsed,
  output logic [AW-1:0] accum,
  output logic [CW-1:0] intervals,
  output logic          running,
  output logic          err,
  output logic          ovf
);
  import perf_timer_pkg::*;

  chan_state_t   state_reg;
  logic [W-1:0]  begin_reg;
  logic [W-1:0]  end_reg;
  logic [W-1:0]  elapsed_reg;
  logic [AW-1:0] accum_reg;
  logic [CW-1:0] intervals_reg;
  logic          err_reg;
  logic          ovf_reg;

  logic [W-1:0]  span;
  logic [AW:0]   accum_sum;
  logic          count_full;
  logic          long_hit;

  // Modular difference handles timestamp wrap inside the interval.
  assign span       = ts - begin_reg;
  assign accum_sum  = {1'b0, accum_reg} + {{(AW + 1 - W){1'b0}}, span};
  assign count_full = &intervals_reg;
  assign long_hit   = (state_reg == RUN) && (&span);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      begin_reg     <= '0;
      end_reg       <= '0;
      elapsed_reg   <= '0;
      accum_reg     <= '0;
      intervals_reg <= '0;
      err_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (clr) begin
      state_reg     <= IDLE;
      begin_reg     <= '0;
      end_reg       <= '0;
      elapsed_reg   <= '0;
      accum_reg     <= '0;
      intervals_reg <= '0;
      err_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      if (long_hit) ovf_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            begin_reg <= ts;
            if (stop) begin
              // Zero-length interval: counted, nothing added to the total.
              end_reg     <= ts;
              elapsed_reg <= '0;
              if (count_full) ovf_reg <= 1'b1;
              else intervals_reg <= intervals_reg + 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end else if (stop) begin
            err_reg <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            end_reg     <= ts;
            elapsed_reg <= span;
            if (accum_sum[AW]) begin
              accum_reg <= '1;
              ovf_reg   <= 1'b1;
            end else begin
              accum_reg <= accum_sum[AW-1:0];
            end
            if (count_full) ovf_reg <= 1'b1;
            else intervals_reg <= intervals_reg + 1'b1;
            // Lap: the closing edge also opens the next interval.
            if (start) begin_reg <= ts;
            else state_reg <= IDLE;
          end else if (start) begin
            err_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign begin_ts  = begin_reg;
  assign end_ts    = end_reg;
  assign elapsed   = elapsed_reg;
  assign accum     = accum_reg;
  assign intervals = intervals_reg;
  assign running   = (state_reg == RUN);
  assign err       = err_reg;
  assign ovf       = ovf_reg;

endmodule

// File: rtl/perf_interval_timer.sv
// Multi-channel interval timer: shared free-running timestamp, NCH channels
// and a registered select-read port for software/debug access.
module perf_interval_timer #(
  parameter int NCH = 4,
  parameter int W   = 32,
  parameter int AW  = 48,
  parameter int CW  = 16,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ts_en,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  input  logic [NCH-1:0] clr,
  input  logic [SW-1:0]  rd_sel,
  input  logic [2:0]     rd_field,
  output logic [W-1:0]   rd_data,
  output logic [NCH-1:0] running,
  output logic [NCH-1:0] err,
  output logic [NCH-1:0] ovf
);
  import perf_timer_pkg::*;

  logic [W-1:0] ts_reg;
  logic [W-1:0] field_word [NCH];
  logic [W-1:0] rd_next;
  logic [W-1:0] rd_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_reg <= '0;
    else if (ts_en) ts_reg <= ts_reg + 1'b1;
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic [W-1:0]  begin_w;
      logic [W-1:0]  end_w;
      logic [W-1:0]  elapsed_w;
      logic [AW-1:0] accum_w;
      logic [CW-1:0] intervals_w;
      logic [W-1:0]  accum_hi_w;

      perf_interval_chan #(
        .W  (W),
        .AW (AW),
        .CW (CW)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .ts        (ts_reg),
        .start     (start[gi]),
        .stop      (stop[gi]),
        .clr       (clr[gi]),
        .begin_ts  (begin_w),
        .end_ts    (end_w),
        .elapsed   (elapsed_w),
        .accum     (accum_w),
        .intervals (intervals_w),
        .running   (running[gi]),
        .err       (err[gi]),
        .ovf       (ovf[gi])
      );

      if (AW > W) begin : g_hi
        assign accum_hi_w = W'(accum_w[AW-1:W]);
      end else begin : g_no_hi
        assign accum_hi_w = '0;
      end

      always_comb begin
        field_word[gi] = '0;
        case (rd_field)
          FLD_BEGIN:    field_word[gi] = begin_w;
          FLD_END:      field_word[gi] = end_w;
          FLD_ELAPSED:  field_word[gi] = elapsed_w;
          FLD_ACCUM_LO: field_word[gi] = accum_w[W-1:0];
          FLD_ACCUM_HI: field_word[gi] = accum_hi_w;
          FLD_COUNT:    field_word[gi] = W'(intervals_w);
          FLD_STATUS: begin
            field_word[gi][ST_RUN_BIT] = running[gi];
            field_word[gi][ST_ERR_BIT] = err[gi];
            field_word[gi][ST_OVF_BIT] = ovf[gi];
          end
          FLD_TS:       field_word[gi] = ts_reg;
          default:      field_word[gi] = '0;
        endcase
      end
    end
  endgenerate

  // Selects with no matching channel fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == SW'(i)) rd_next = field_word[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_reg <= '0;
    else rd_data_reg <= rd_next;
  end

  assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_perf_interval_timer.sv
// Self-checking bench: directed scenarios plus random pulses, compared every
// cycle against a behavioural model of the channel rules.
module tb_perf_interval_timer;
  localparam int NCH    = 3;
  localparam int W      = 8;
  localparam int AW     = 10;
  localparam int CW     = 4;
  localparam int TSMOD  = 1 << W;
  localparam int MAXACC = (1 << AW) - 1;
  localparam int MAXCNT = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           ts_en;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] clr;
  logic [1:0]     rd_sel;
  logic [2:0]     rd_field;
  logic [W-1:0]   rd_data;
  logic [NCH-1:0] running;
  logic [NCH-1:0] err;
  logic [NCH-1:0] ovf;

  int checks = 0;
  int errors = 0;

  int m_ts;
  bit m_run [NCH];
  int m_beg [NCH];
  int m_end [NCH];
  int m_el  [NCH];
  int m_acc [NCH];
  int m_cnt [NCH];
  bit m_err [NCH];
  bit m_ovf [NCH];

  perf_interval_timer #(.NCH(NCH), .W(W), .AW(AW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ts_en    (ts_en),
    .start    (start),
    .stop     (stop),
    .clr      (clr),
    .rd_sel   (rd_sel),
    .rd_field (rd_field),
    .rd_data  (rd_data),
    .running  (running),
    .err      (err),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ts = 0;
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_beg[i] = 0; m_end[i] = 0; m_el[i] = 0;
      m_acc[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_ovf[i] = 0;
    end
  endtask

  function automatic int exp_field(input int sel, input int fld);
    if (sel >= NCH) return 0;
    case (fld)
      0: return m_beg[sel];
      1: return m_end[sel];
      2: return m_el[sel];
      3: return m_acc[sel] % TSMOD;
      4: return m_acc[sel] / TSMOD;
      5: return m_cnt[sel];
      6: return 4 * int'(m_ovf[sel]) + 2 * int'(m_err[sel]) + int'(m_run[sel]);
      default: return m_ts;
    endcase
  endfunction

  task automatic count_interval(input int i);
    if (m_cnt[i] == MAXCNT) m_ovf[i] = 1;
    else m_cnt[i]++;
  endtask

  // Applies one clock edge worth of the channel rules to the model.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      int span;
      span = (m_ts - m_beg[i] + TSMOD) % TSMOD;
      if (clr[i]) begin
        m_run[i] = 0; m_beg[i] = 0; m_end[i] = 0; m_el[i] = 0;
        m_acc[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_ovf[i] = 0;
      end else begin
        if (m_run[i] && span == TSMOD - 1) m_ovf[i] = 1;
        if (!m_run[i]) begin
          if (start[i] && stop[i]) begin
            m_beg[i] = m_ts; m_end[i] = m_ts; m_el[i] = 0;
            count_interval(i);
          end else if (start[i]) begin
            m_beg[i] = m_ts; m_run[i] = 1;
          end else if (stop[i]) begin
            m_err[i] = 1;
          end
        end else if (stop[i]) begin
          m_end[i] = m_ts;
          m_el[i]  = span;
          m_acc[i] = m_acc[i] + span;
          if (m_acc[i] > MAXACC) begin
            m_acc[i] = MAXACC;
            m_ovf[i] = 1;
          end
          count_interval(i);
          if (start[i]) m_beg[i] = m_ts;
          else m_run[i] = 0;
        end else if (start[i]) begin
          m_err[i] = 1;
        end
      end
    end
    if (ts_en) m_ts = (m_ts + 1) % TSMOD;
  endtask

  task automatic tick();
    int e_rd;
    logic [NCH-1:0] e_run, e_err, e_ovf;
    e_rd = exp_field(int'(rd_sel), int'(rd_field));
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      e_run[i] = m_run[i]; e_err[i] = m_err[i]; e_ovf[i] = m_ovf[i];
    end
    check("rd_data", 32'(rd_data), 32'(e_rd));
    check("running", 32'(running), 32'(e_run));
    check("err", 32'(err), 32'(e_err));
    check("ovf", 32'(ovf), 32'(e_ovf));
    start = '0; stop = '0; clr = '0;
  endtask

  task automatic wait_ts(input int target);
    int n = 0;
    while (m_ts != target && n < 2 * TSMOD) begin
      tick();
      n++;
    end
    check("wait_ts_bound", 32'(m_ts), 32'(target));
  endtask

  task automatic read_expect(input int sel, input int fld, input int expv, input string tag);
    rd_sel = 2'(sel);
    rd_field = 3'(fld);
    tick();
    check(tag, 32'(rd_data), 32'(expv));
  endtask

  initial begin
    rst = 1'b1; ts_en = 1'b1; start = '0; stop = '0; clr = '0;
    rd_sel = '0; rd_field = '0;
    model_reset();
    #1;
    check("reset_rd_data", 32'(rd_data), 0);
    check("reset_running", 32'(running), 0);
    check("reset_err_ovf", 32'({err, ovf}), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic interval on ch0.
    wait_ts(10); start[0] = 1'b1; tick();
    wait_ts(35); stop[0] = 1'b1; tick();
    check("basic_running0", 32'(running[0]), 0);
    read_expect(0, 0, 10, "basic_begin");
    read_expect(0, 1, 35, "basic_end");
    read_expect(0, 2, 25, "basic_elapsed");
    read_expect(0, 3, 25, "basic_accum");
    read_expect(0, 5, 1, "basic_intervals");

    // Timestamp wrap inside an interval on ch1.
    wait_ts(250); start[1] = 1'b1; tick();
    wait_ts(4); stop[1] = 1'b1; tick();
    read_expect(1, 2, 10, "wrap_elapsed");

    // Long interval on ch2: ovf exactly when ts-begin reaches 2^W-1.
    start[2] = 1'b1; tick();
    repeat (TSMOD - 2) tick();
    check("long_ovf_before", 32'(ovf[2]), 0);
    tick();
    check("long_ovf_set", 32'(ovf[2]), 1);
    clr[2] = 1'b1; tick();

    // Lap on ch0.
    clr[0] = 1'b1; tick();
    wait_ts(5); start[0] = 1'b1; tick();
    wait_ts(15); start[0] = 1'b1; stop[0] = 1'b1; tick();
    wait_ts(40); stop[0] = 1'b1; tick();
    read_expect(0, 2, 25, "lap_elapsed");
    read_expect(0, 3, 35, "lap_accum");
    read_expect(0, 5, 2, "lap_intervals");

    // Protocol errors on ch1.
    clr[1] = 1'b1; tick();
    stop[1] = 1'b1; tick();
    check("err_stop_idle", 32'(err[1]), 1);
    read_expect(1, 5, 0, "err_no_count");
    wait_ts(100); start[1] = 1'b1; tick();
    start[1] = 1'b1; tick();
    read_expect(1, 0, 100, "err_begin_kept");
    clr[1] = 1'b1; tick();
    check("clr_err", 32'(err[1]), 0);
    read_expect(1, 0, 0, "clr_begin");
    read_expect(1, 3, 0, "clr_accum");

    // Simultaneous start+stop in IDLE, then clr overriding start.
    clr[0] = 1'b1; tick();
    wait_ts(7); start[0] = 1'b1; stop[0] = 1'b1; tick();
    read_expect(0, 0, 7, "zero_begin");
    read_expect(0, 1, 7, "zero_end");
    read_expect(0, 2, 0, "zero_elapsed");
    read_expect(0, 5, 1, "zero_intervals");
    start[0] = 1'b1; clr[0] = 1'b1; tick();
    check("clr_start_idle", 32'(running[0]), 0);
    read_expect(0, 5, 0, "clr_start_zero");

    // Read port: status word and out-of-range select.
    start[1] = 1'b1; tick();
    read_expect(1, 6, 1, "status_running");
    read_expect(3, 7, 0, "oob_select");

    // Accumulator saturation on ch2: six 200-cycle intervals exceed 2^AW-1.
    clr[2] = 1'b1; tick();
    for (int k = 0; k < 6; k++) begin
      start[2] = 1'b1; tick();
      repeat (199) tick();
      stop[2] = 1'b1; tick();
      if (k == 4) check("accum_no_ovf_yet", 32'(ovf[2]), 0);
    end
    check("accum_sat_ovf", 32'(ovf[2]), 1);
    read_expect(2, 3, MAXACC % TSMOD, "accum_sat_lo");
    read_expect(2, 4, MAXACC / TSMOD, "accum_sat_hi");

    // Randomized pulses, reads and timestamp gating.
    repeat (1500) begin
      ts_en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NCH; i++) begin
        start[i] = ($urandom_range(0, 5) == 0);
        stop[i]  = ($urandom_range(0, 5) == 0);
        clr[i]   = ($urandom_range(0, 200) == 0);
      end
      rd_sel   = 2'($urandom_range(0, 3));
      rd_field = 3'($urandom_range(0, 7));
      tick();
    end

    // Asynchronous reset in the middle of an interval.
    ts_en = 1'b1;
    clr[0] = 1'b1; tick();
    start[0] = 1'b1; rd_sel = 2'd0; rd_field = 3'd7; tick();
    check("pre_rst_running", 32'(running[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_running", 32'(running), 0);
    check("async_rst_flags", 32'({err, ovf}), 0);
    check("async_rst_rd_data", 32'(rd_data), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    read_expect(0, 0, 0, "post_rst_begin");
    read_expect(0, 5, 0, "post_rst_intervals");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_interval_timer.md
Name: perf_interval_timer

Overview:
- Multi-channel interval timer; parametrised successor of the single begin/end count capture block.
- One shared free-running timestamp feeds NCH independent channels.
- Each channel measures start→stop intervals, latches begin/end timestamps, computes elapsed time, and accumulates total time and interval count.
- Sits beside the CPU datapath; software reads results through a registered select-read port (for LED/debug display).

Parameters:
- NCH, 4, number of channels (1..16).
- W, 32, timestamp / begin / end / elapsed width.
- AW, 48, accumulated-total width (AW ≥ W).
- CW, 16, interval-count width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- ts_en  in  1  timestamp advances when 1.
- start  in  NCH  per-channel start pulse.
- stop  in  NCH  per-channel stop pulse.
- clr  in  NCH  per-channel synchronous clear.
- rd_sel  in  $clog2(NCH) (min 1)  channel select.
- rd_field  in  3  0=begin 1=end 2=elapsed 3=accum[W-1:0] 4=accum[AW-1:W] zero-extended 5=intervals 6=status 7=timestamp.
- rd_data  out  W  registered read data.
- running  out  NCH  channel in RUN.
- err  out  NCH  sticky protocol error.
- ovf  out  NCH  sticky overflow.

Behaviour:
- Reset (async, rst=1): timestamp, all channel registers, rd_data, running, err, ovf = 0. All FSMs go to IDLE.
- Timestamp ts: W-bit, +1 per cycle when ts_en=1, wraps 2^W-1→0.
- "ts" below means the register value in the cycle the pulse is sampled.
- Channel FSM states: IDLE, RUN. `running` = (state==RUN).
- IDLE & start & !stop: begin←ts; →RUN.
- IDLE & start & stop: zero-length interval. begin←ts, end←ts, elapsed←0, intervals+1; stay IDLE.
- IDLE & stop only: ignored; err←1.
- RUN & stop & !start: end←ts; elapsed←(ts-begin) mod 2^W; accum+=elapsed; intervals+1; →IDLE.
- RUN & stop & start (lap): close the interval as above, then begin←ts; stay RUN.
- RUN & start only: ignored; err←1.
- Saturation: accum saturates at 2^AW-1 and sets ovf. intervals saturates at 2^CW-1 and sets ovf.
- Long interval: while RUN, if (ts-begin)==2^W-1, set ovf. Elapsed is modular thereafter and is not corrected.
- clr[i]: highest priority over start/stop for channel i. Zeroes begin/end/elapsed/accum/intervals/err/ovf and forces IDLE. No effect on ts or other channels.
- Results update at the clock edge after the pulse. Visible on rd_data one further cycle later.
- Read path: rd_data registered, 1-cycle latency from rd_sel/rd_field. It reflects register values at the sampling edge, not same-cycle updates.
- Out-of-range rd_sel (≥NCH) → rd_data=0.
- Status word = {W-3 zeros, ovf, err, running}.
- Mid-interval reset: everything cleared, interval lost, no error flagged.

Decomposition:
- Package perf_timer_pkg:
  - rd_field encodings (FLD_BEGIN..FLD_TS).
  - State enum (IDLE, RUN).
  - Status bit positions.
- One natural sub-module, perf_interval_chan: per-channel FSM plus begin/end/elapsed/accum/intervals/flags.
- Top instantiates NCH copies, the shared timestamp, and the registered read mux.

Test Plan:
- Reset, ts_en=1, start[0] at ts=10, stop[0] at ts=35 → begin=10, end=35, elapsed=25, accum=25, intervals=1, running[0]=0.
- Wrap: W=8, start at ts=250, stop at ts=4 → elapsed=10. Hold RUN 255 cycles → ovf=1.
- Lap: start at 5, start+stop at 15, stop at 40 → elapsed=25, accum=35, intervals=2.
- Errors: stop in IDLE → err=1, no count change. start in RUN → err=1, begin unchanged. clr → err=0, all fields 0.
- Simultaneous: start+stop in IDLE at ts=7 → begin=end=7, elapsed=0, intervals=1. clr with start same cycle → IDLE, zeros.
- Read port: rd_sel=1, rd_field=6 with ch1 running → rd_data=1 one cycle later. rd_sel=NCH → 0. Async rst mid-RUN → all outputs 0 immediately.
